demux1_4_buf: RTL

Buffered 1-to-4 steering block: the write-side counterpart of the 4:1 datapath mux. It accepts one N-bit word per cycle with a 2-bit destination select and delivers it through one of four independent valid/ready output channels, each backed by a one-entry holding register. It also keeps per-channel delivery counters behind a 4:1 readback select. It sits wherever one producer in the multi-cycle datapath must feed one of four consumers that may stall independently.

---
 rtl/demux1_4_buf.sv | 115 +++++++++++
 1 files changed

// File: rtl/demux1_4_buf.sv
`default_nettype none
// ============================================================================
// Module   : demux1_4_buf
// Brief    : Buffered 1-to-4 steering block. One N-bit word per cycle is
//            routed by a 2-bit select into one of four independent
//            valid/ready channels, each backed by a one-entry holding
//            register. Per-channel delivery counters are read back through
//            a 4:1 select.
// Revision : 1.0 - initial release
// ============================================================================
module demux1_4_buf #(
   parameter int N  = 32,
   parameter int CW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  in_data,
   input  logic [1:0]    in_ctrl,
   input  logic          in_valid,
   output logic          in_ready,
   output logic [N-1:0]  A,
   output logic [N-1:0]  B,
   output logic [N-1:0]  C,
   output logic [N-1:0]  D,
   output logic [3:0]    out_valid,
   input  logic [3:0]    out_ready,
   input  logic [1:0]    cnt_sel,
   input  logic          cnt_clr,
   output logic [CW-1:0] cnt_out,
   output logic          idle
);

   localparam int          c_nch     = 4;
   localparam logic [CW-1:0] c_cnt_one = {{(CW-1){1'b0}}, 1'b1};

   // Per-channel state
   logic [N-1:0]  r_hold [c_nch];
   logic [3:0]    r_v;
   logic [CW-1:0] r_cnt  [c_nch];

   // Transfer qualifiers
   logic          w_push;
   logic [3:0]    w_push_vec;
   logic [3:0]    w_pop_vec;

   // Accept when the selected slot is empty or is being drained this cycle;
   // the out_ready -> in_ready path is what gives full throughput.
   always_comb begin
      in_ready = ~r_v[in_ctrl] | out_ready[in_ctrl];
   end

   // Decode the single push into a one-hot channel vector; pops are per channel.
   always_comb begin
      w_push     = in_valid & in_ready;
      w_push_vec = 4'b0000;
      if (w_push) begin
         w_push_vec[in_ctrl] = 1'b1;
      end
      w_pop_vec  = r_v & out_ready;
   end

   generate
      for (genvar k = 0; k < c_nch; k++) begin : g_chan

         // Holding register and valid flag: push wins over pop on the same
         // channel, so a simultaneous push/pop keeps the slot occupied.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_hold[k] <= '0;
               r_v[k]    <= 1'b0;
            end else if (w_push_vec[k]) begin
               r_hold[k] <= in_data;
               r_v[k]    <= 1'b1;
            end else if (w_pop_vec[k]) begin
               r_v[k]    <= 1'b0;
            end
         end

         // Delivery counter: wraps naturally; a clear drops that cycle's pop.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               r_cnt[k] <= '0;
            end else if (cnt_clr) begin
               r_cnt[k] <= '0;
            end else if (w_pop_vec[k]) begin
               r_cnt[k] <= r_cnt[k] + c_cnt_one;
            end
         end

      end
   endgenerate

   // Channel outputs and status; hold contents persist after a pop.
   always_comb begin
      A         = r_hold[0];
      B         = r_hold[1];
      C         = r_hold[2];
      D         = r_hold[3];
      out_valid = r_v;
      idle      = ~|r_v;
   end

   // Counter readback select.
   always_comb begin
      cnt_out = '0;
      case (cnt_sel)
         2'd0:    cnt_out = r_cnt[0];
         2'd1:    cnt_out = r_cnt[1];
         2'd2:    cnt_out = r_cnt[2];
         default: cnt_out = r_cnt[3];
      endcase
   end

endmodule
`default_nettype wire
